// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART receive/transmit paths.
//   uart_rx_state_t : receiver FSM state encoding.
//   tick_div()      : system clocks per oversampling tick (integer division).
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_rx_state_t;

  function automatic int unsigned tick_div(input int unsigned clk,
                                           input int unsigned baud,
                                           input int unsigned os);
    return clk / (baud * os);
  endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// uart_tick_gen: free-running oversampling tick divider.
//   clock  : system clock (rising edge)
//   nreset : asynchronous active-low reset
//   clear  : forces the counter to 0 on the next edge (realigns the tick grid)
//   tick   : one-cycle pulse while the counter sits at TICK_DIV-1
module uart_tick_gen #(
  parameter int unsigned TICK_DIV = 2
) (
  input  logic clock,
  input  logic nreset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1-style asynchronous serial receiver with mid-bit sampling.
//   clock       : system clock (rising edge)
//   nreset      : asynchronous active-low reset
//   rx          : serial line, asynchronous, idle high
//   data_out    : last byte received with a good stop bit
//   data_valid  : one-cycle pulse when data_out updates
//   frame_error : one-cycle pulse when the stop bit is sampled low
//   busy        : high while the FSM is outside IDLE
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_INPUT  = 50_000_000,
  parameter int unsigned BAUDRATE     = 9600,
  parameter int unsigned OVERSAMPLING = 8,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic                 clock,
  input  logic                 nreset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_error,
  output logic                 busy
);

  localparam int unsigned TICK_DIV = tick_div(CLOCK_INPUT, BAUDRATE, OVERSAMPLING);
  localparam int unsigned OS_W     = $clog2(OVERSAMPLING);
  localparam int unsigned BIT_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [OS_W-1:0]  OS_HALF = OS_W'(OVERSAMPLING / 2 - 1);
  localparam logic [OS_W-1:0]  OS_LAST = OS_W'(OVERSAMPLING - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  logic rx_meta_q, rx_s_q, rx_d_q;
  logic fall_edge, tick, tick_clear;

  uart_rx_state_t       state_q, state_d;
  logic [OS_W-1:0]      os_q, os_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;

  // Two-flop synchroniser plus one delay stage for edge detection; idle-high reset
  // values keep a released reset from looking like a start edge.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_d_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_d_q    <= rx_s_q;
    end
  end

  assign fall_edge = rx_d_q & ~rx_s_q;

  uart_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clock (clock),
    .nreset(nreset),
    .clear (tick_clear),
    .tick  (tick)
  );

  always_comb begin
    state_d    = state_q;
    os_d       = os_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;
    tick_clear = 1'b0;

    case (state_q)
      IDLE: begin
        if (fall_edge) begin
          state_d    = START;
          os_d       = '0;
          tick_clear = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          if (os_q == OS_HALF) begin
            os_d  = '0;
            bit_d = '0;
            // A line already back high at mid start bit was a glitch.
            state_d = rx_s_q ? IDLE : DATA;
          end else begin
            os_d = os_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (os_q == OS_LAST) begin
            os_d    = '0;
            shift_d = DATA_BITS'({rx_s_q, shift_q} >> 1);
            if (bit_q == BIT_LAST) begin
              state_d = STOP;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            os_d = os_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (os_q == OS_LAST) begin
            os_d    = '0;
            state_d = IDLE;
            if (rx_s_q) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ferr_d = 1'b1;
            end
          end else begin
            os_d = os_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      os_q    <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      os_q    <= os_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign data_out    = data_q;
  assign data_valid  = valid_q;
  assign frame_error = ferr_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx (TICK_DIV=2, 16 clocks per bit).
// Frames come from a vector table; expected outputs are queued as each frame is
// driven and popped by a monitor when data_valid/frame_error pulses.
module tb_uart_rx;

  logic       clock = 1'b0;
  logic       nreset;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_error;
  logic       busy;

  uart_rx #(
    .CLOCK_INPUT (1_600_000),
    .BAUDRATE    (100_000),
    .OVERSAMPLING(8),
    .DATA_BITS   (8)
  ) dut (
    .clock      (clock),
    .nreset     (nreset),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_error(frame_error),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         start_len;
    int         bit_len;
    int         idle;
    logic       hold_low;
  } vec_t;

  localparam int NV = 6;

  exp_t sb_q[$];
  vec_t vecs[NV];
  int   checks = 0;
  int   failures = 0;
  int   busy_cycles = 0;
  int   ev_count = 0;
  logic prev_pulse = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Drive one clock of line level, then sample busy mid-cycle.
  task automatic drive_cycle(input logic v);
    @(posedge clock);
    #1 rx = v;
    @(negedge clock);
    if (busy) busy_cycles++;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input int start_len, input int bit_len);
    for (int i = 0; i < start_len; i++) drive_cycle(1'b0);
    for (int j = 0; j < 8; j++)
      for (int i = 0; i < bit_len; i++) drive_cycle(b[j]);
    for (int i = 0; i < 16; i++) drive_cycle(stop);
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (!nreset) begin
      prev_pulse = 1'b0;
    end else begin
      if (data_valid || frame_error) begin
        ev_count++;
        check("pulse_excl", 32'(data_valid & frame_error), 32'd0);
        check("pulse_width", 32'(prev_pulse), 32'd0);
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got valid=%0b err=%0b data=0x%02h expected no pulse",
                   data_valid, frame_error, data_out);
        end else begin
          e = sb_q.pop_front();
          check("sb_err", 32'(frame_error), 32'(e.err));
          check("sb_data", 32'(data_out), 32'(e.data));
        end
      end
      prev_pulse = data_valid | frame_error;
    end
  end

  initial begin
    logic [7:0] last_good;
    int         ev0;

    // Last row: data bits stretched to 17 clocks, so the stop bit starts 8
    // clocks late -- the whole half-bit margin.
    vecs[0] = '{8'hA5, 1'b1, 16, 16, 20, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 16, 16, 10, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 16, 16, 0,  1'b0};
    vecs[3] = '{8'h3C, 1'b0, 16, 16, 10, 1'b1};
    vecs[4] = '{8'h12, 1'b1, 16, 16, 20, 1'b0};
    vecs[5] = '{8'h55, 1'b1, 16, 17, 20, 1'b0};

    rx        = 1'b1;
    nreset    = 1'b0;
    last_good = 8'h00;
    repeat (3) @(negedge clock);
    check("reset_outputs", 32'({data_out, data_valid, frame_error, busy}), 32'd0);
    @(posedge clock);
    #1 nreset = 1'b1;
    repeat (5) drive_cycle(1'b1);
    check("post_reset_idle", 32'({data_out, busy}), 32'd0);

    for (int i = 0; i < NV; i++) begin
      for (int k = 0; k < vecs[i].idle; k++) drive_cycle(1'b1);
      if (vecs[i].stop) begin
        sb_q.push_back({1'b0, vecs[i].data});
        last_good = vecs[i].data;
      end else begin
        sb_q.push_back({1'b1, last_good});
      end
      busy_cycles = 0;
      ev0 = ev_count;
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].start_len, vecs[i].bit_len);
      check($sformatf("row%0d_busy_cycles", i), 32'(busy_cycles), 32'd152);
      check($sformatf("row%0d_events", i), 32'(ev_count - ev0), 32'd1);
      check($sformatf("row%0d_data_out", i), 32'(data_out), 32'(last_good));
      if (vecs[i].hold_low) begin
        busy_cycles = 0;
        for (int k = 0; k < 200; k++) drive_cycle(1'b0);
        check($sformatf("row%0d_held_low_busy", i), 32'(busy_cycles), 32'd0);
      end
    end

    // Glitch: 4-clock low pulse is rejected at the mid start-bit sample.
    for (int k = 0; k < 20; k++) drive_cycle(1'b1);
    busy_cycles = 0;
    ev0 = ev_count;
    for (int k = 0; k < 4; k++) drive_cycle(1'b0);
    for (int k = 0; k < 12; k++) drive_cycle(1'b1);
    check("glitch_busy_low", 32'(busy), 32'd0);
    check("glitch_busy_cycles", 32'(busy_cycles), 32'd8);
    for (int k = 0; k < 20; k++) drive_cycle(1'b1);
    check("glitch_no_event", 32'(ev_count - ev0), 32'd0);

    // Reset during bit 3 of 0x81; the partial byte must vanish.
    ev0 = ev_count;
    for (int k = 0; k < 16; k++) drive_cycle(1'b0);
    for (int k = 0; k < 16; k++) drive_cycle(1'b1);
    for (int k = 0; k < 16; k++) drive_cycle(1'b0);
    for (int k = 0; k < 16; k++) drive_cycle(1'b0);
    for (int k = 0; k < 8; k++) drive_cycle(1'b0);
    @(posedge clock);
    #1 nreset = 1'b0;
    rx = 1'b1;
    @(negedge clock);
    check("midframe_reset_outputs", 32'({data_out, data_valid, frame_error, busy}), 32'd0);
    repeat (3) @(negedge clock);
    check("midframe_reset_hold", 32'({data_out, data_valid, frame_error, busy}), 32'd0);
    @(posedge clock);
    #1 nreset = 1'b1;
    for (int k = 0; k < 20; k++) drive_cycle(1'b1);
    sb_q.push_back({1'b0, 8'h5A});
    send_frame(8'h5A, 1'b1, 16, 16);
    check("after_reset_events", 32'(ev_count - ev0), 32'd1);
    check("after_reset_data_out", 32'(data_out), 32'h5A);

    for (int k = 0; k < 500 && sb_q.size() != 0; k++) drive_cycle(1'b1);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver, 8N1, with its own oversampling tick divider. It converts the `rx` pin into parallel bytes and is the receive-side counterpart of the UART transmit path and baud-rate generation. It resynchronises the line, detects and qualifies the start bit, and samples each bit at mid-bit on the oversampling grid. Each byte is delivered with a one-cycle valid strobe, and bad stop bits are flagged.

## Interface
- `CLOCK_INPUT`, default 50_000_000: system clock frequency in Hz.
- `BAUDRATE`, default 9600: line bit rate.
- `OVERSAMPLING`, default 8: ticks per bit. Must be even and ≥4.
- `DATA_BITS`, default 8: payload bits per frame, LSB first.

- `clock` input 1: system clock. All logic is on the rising edge.
- `nreset` input 1: asynchronous, active-low reset. There is only one clock.
- `rx` input 1: serial line, asynchronous to `clock`. Idle level is high.
- `data_out` output DATA_BITS: last good byte. Holds until the next good frame.
- `data_valid` output 1: one-cycle pulse when `data_out` is updated.
- `frame_error` output 1: one-cycle pulse when the stop bit is sampled low.
- `busy` output 1: high while the FSM is outside IDLE.

## Operation
- **Synchroniser.** `rx` passes through 2 flops (reset value 1) to give `rx_s`. A third flop holds `rx_d`, the previous `rx_s`.
- **Falling edge.** The edge is `rx_d & ~rx_s`.
- **Tick divider.**
  - `TICK_DIV = CLOCK_INPUT/(BAUDRATE*OVERSAMPLING)`, using integer division.
  - The counter is `$clog2(TICK_DIV)` bits wide, counts 0..TICK_DIV-1, and wraps.
  - `tick` is high for one cycle at the wrap.
  - The counter is forced to 0 on the cycle the start edge is accepted, which aligns the tick grid to the edge.
- **Counters.** `os_cnt` counts ticks within a bit, range 0..OVERSAMPLING-1. `bit_cnt` counts data bits, range 0..DATA_BITS-1.
- **FSM states:** IDLE, START, DATA, STOP.
- **IDLE → START** on a falling edge. `os_cnt` and the tick counter are cleared.
- **START.**
  - When `os_cnt` reaches OVERSAMPLING/2-1 on a tick, `rx_s` is sampled.
  - If `rx_s` is 0: `os_cnt` clears, `bit_cnt` clears, and the FSM goes to DATA.
  - If `rx_s` is 1: the start bit was a glitch. The FSM returns to IDLE with no output.
- **DATA.**
  - When `os_cnt` reaches OVERSAMPLING-1 on a tick, `rx_s` is shifted into the shift register MSB and the register shifts right, giving LSB-first assembly.
  - After DATA_BITS samples the FSM goes to STOP.
- **STOP.**
  - When `os_cnt` reaches OVERSAMPLING-1 on a tick, the stop bit is sampled.
  - Sample 1: `data_out` ← shift register and `data_valid` pulses.
  - Sample 0: `frame_error` pulses and `data_out` is unchanged.
  - Either way the FSM goes to IDLE.
- **Line held low** (break, or after a frame error): no new start is accepted until `rx_s` has been high and falls again, because the falling-edge qualifier requires this.
- **Mid-frame reset** (`nreset` low at any time): all state returns to reset values and any partial byte is discarded.

## Timing
- **Reset values:**
  - `data_out` = 0, `data_valid` = 0, `frame_error` = 0, `busy` = 0.
  - Synchroniser flops = 1, FSM = IDLE.
  - All counters = 0.
- **Input latency:** 2 cycles from the `rx` pin to `rx_s`. Edge detection adds 1 cycle.
- **Sample points:**
  - Start bit is sampled (OVERSAMPLING/2)·TICK_DIV cycles after the edge is accepted.
  - Each later bit is sampled OVERSAMPLING·TICK_DIV cycles after the previous sample.
- **Outputs:** `data_valid` and `frame_error` are registered. Each goes high on the cycle after the stop-bit sample tick, for exactly 1 cycle. The two are never high together.
- **busy:** rises the cycle after the edge is accepted. Falls together with the `data_valid` or `frame_error` pulse, or on the cycle after a glitch reject.
- **Back-to-back frames:** a falling edge on the cycle the FSM is in IDLE after STOP is accepted. There is no idle gap requirement beyond the stop bit's second half.

## Structure
- **Package `uart_pkg`:**
  - State enum typedef `uart_rx_state_t` (IDLE, START, DATA, STOP).
  - Function `tick_div(clk, baud, os)` returning the divider value, shared with the transmitter.
- **Sub-module `uart_tick_gen`:**
  - Parameter TICK_DIV.
  - Ports: `clock`, `nreset`, `clear`, `tick`.
  - Also reused by the transmitter.
- The FSM, shift register and counters live in `uart_rx` itself.

## Test plan
Bench parameters: CLOCK_INPUT=1_600_000, BAUDRATE=100_000, OVERSAMPLING=8, DATA_BITS=8. This gives TICK_DIV=2, so one bit is 16 clocks.

- **Single frame:** send 0xA5 (start bit, then bits 1,0,1,0,0,1,0,1, then stop).
  - Required: `data_out`=0xA5 with one `data_valid` pulse, `frame_error`=0.
  - Required: `busy` high for about 152 cycles (START 8 + DATA 128 + STOP 16 clocks).
- **Back-to-back:** send 0x00 then 0xFF with no idle gap. Required: two `data_valid` pulses with `data_out` = 0x00 then 0xFF.
- **Glitch:** a 4-clock low pulse on an idle line. Required: `busy` returns low within 12 cycles, with no `data_valid` and no `frame_error`.
- **Frame error:** send 0x3C with stop bit = 0.
  - Required: a `frame_error` pulse, and `data_out` keeps its previous value of 0xFF.
  - Required: with the line then held low for 200 cycles, `busy` stays 0. Raising the line and sending 0x12 then yields 0x12.
- **Reset mid-frame:** pull `nreset` low during bit 3 of 0x81, then send 0x5A. Required: all outputs 0 during reset, then exactly one `data_valid` with 0x5A.
- **Timing jitter:** send 0x55 with the bit period stretched to 17 clocks. Required: 0x55 received with no error, because the mid-bit margin holds.
